fwupd_uaddr_gen: RTL and testbench



---
 rtl/fwupd_uaddr_gen.sv | 84 ++++++++
 tb/tb_fwupd_uaddr_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fwupd_uaddr_gen.sv
// fwupd_uaddr_gen
//   8-bit pseudo-random address sequencer for the firmware-update path.
//   A maximal-length Fibonacci LFSR (taps 8,6,5,4) advances once per clock
//   enable and its registered state is presented as the update address.
//   A one-cycle wrap flag marks the step that brings the sequence back to
//   its seed.
//
// Configuration:
//   FWUPD_UADDR_ZERO_EN  when defined, the sequence is extended to de Bruijn
//                        form (period 256, includes 0x00) and SEED=8'h00 is
//                        legal. When undefined, the period is 255, 0x00 is
//                        never produced, and SEED=8'h00 is replaced by 8'h01.
//
// Parameters:
//   SEED     reset/start state of the sequence (default 8'h01)
//
// Ports:
//   clk_i    in   1  system clock, rising edge
//   rst_i    in   1  asynchronous active-high reset
//   ce_i     in   1  clock enable; one LFSR step per enabled edge
//   uaddr_o  out  8  current address (registered LFSR state)
//   wrap_o   out  1  registered pulse, high in the cycle uaddr_o returns to
//                    the seed by stepping

module fwupd_uaddr_gen #(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ce_i,
    output logic [7:0] uaddr_o,
    output logic       wrap_o
);

`ifdef FWUPD_UADDR_ZERO_EN
    localparam logic [7:0] SEED_EFF = SEED;
`else
    // All-zero is a lock-up state of the plain LFSR, so it cannot be a seed.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
`endif

    logic [7:0] uaddr_q;
    logic [7:0] uaddr_d;
    logic       wrap_q;
    logic       wrap_d;
    logic       fb;
    logic [7:0] step_val;

    always_comb begin
        fb       = uaddr_q[7] ^ uaddr_q[5] ^ uaddr_q[4] ^ uaddr_q[3];
        step_val = {uaddr_q[6:0], fb};
`ifdef FWUPD_UADDR_ZERO_EN
        // De Bruijn extension: inverting feedback when the low seven bits are
        // zero splices 0x00 in between 0x80 and 0x01.
        step_val = {uaddr_q[6:0], fb ^ (uaddr_q[6:0] == 7'h00)};
`else
        // A forced zero state would otherwise step to itself forever.
        if (uaddr_q == 8'h00) begin
            step_val = 8'h01;
        end
`endif

        uaddr_d = uaddr_q;
        wrap_d  = 1'b0;
        if (ce_i) begin
            uaddr_d = step_val;
            wrap_d  = (step_val == SEED_EFF);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            uaddr_q <= SEED_EFF;
            wrap_q  <= 1'b0;
        end else begin
            uaddr_q <= uaddr_d;
            wrap_q  <= wrap_d;
        end
    end

    assign uaddr_o = uaddr_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_fwupd_uaddr_gen.sv
// Directed bench for fwupd_uaddr_gen with SEED=8'h01.
module tb_fwupd_uaddr_gen;

    logic       clk;
    logic       rst;
    logic       ce;
    logic [7:0] uaddr;
    logic       wrap;

    int unsigned checks = 0;
    int unsigned errors = 0;

`ifdef FWUPD_UADDR_ZERO_EN
    localparam int unsigned PERIOD = 256;
`else
    localparam int unsigned PERIOD = 255;
`endif

    fwupd_uaddr_gen #(.SEED(8'h01)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .ce_i   (ce),
        .uaddr_o(uaddr),
        .wrap_o (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference step taken directly from the tap polynomial x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] ref_next(input logic [7:0] q);
        logic b;
        b = q[7] ^ q[5] ^ q[4] ^ q[3];
`ifdef FWUPD_UADDR_ZERO_EN
        if (q[6:0] == 7'h00) b = ~b;
`endif
        return {q[6:0], b};
    endfunction

    // One clock: inputs set at the falling edge, outputs sampled 1 after rise.
    task automatic tick(input logic ce_v);
        @(negedge clk);
        ce = ce_v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ce  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] exp_seq [6];
    logic [7:0] model;
    bit         seen [256];
    int unsigned distinct;
    int unsigned wraps;
    int unsigned zeros;

    initial begin
        exp_seq[0] = 8'h02; exp_seq[1] = 8'h04; exp_seq[2] = 8'h08;
        exp_seq[3] = 8'h11; exp_seq[4] = 8'h23; exp_seq[5] = 8'h47;

        // Asynchronous reset before any clock edge.
        rst = 1'b1;
        ce  = 1'b0;
        #1;
        check("rst_uaddr_async", {24'h0, uaddr}, 32'h01);
        check("rst_wrap_async", {31'h0, wrap}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick(1'b0);
        check("post_rst_hold", {24'h0, uaddr}, 32'h01);

        // Slow strobe: one ce cycle in every eight.
        for (int k = 0; k < 6; k++) begin
            tick(1'b1);
            check("slow_step", {24'h0, uaddr}, {24'h0, exp_seq[k]});
            check("slow_step_wrap", {31'h0, wrap}, 32'h0);
            for (int h = 0; h < 7; h++) begin
                tick(1'b0);
                check("slow_hold", {24'h0, uaddr}, {24'h0, exp_seq[k]});
            end
        end

        // Full period with ce held high: one step per clock.
        do_reset();
        model    = 8'h01;
        distinct = 0;
        wraps    = 0;
        zeros    = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int unsigned n = 1; n <= PERIOD; n++) begin
            tick(1'b1);
            model = ref_next(model);
            check("full_uaddr", {24'h0, uaddr}, {24'h0, model});
            check("full_wrap", {31'h0, wrap}, {31'h0, (n == PERIOD)});
            if (wrap) wraps++;
            if (uaddr == 8'h00) zeros++;
            if (!seen[uaddr]) begin
                seen[uaddr] = 1'b1;
                distinct++;
            end
        end
        check("wrap_at_seed", {24'h0, uaddr}, 32'h01);
        check("wrap_count", wraps, 32'd1);
        check("distinct_values", distinct, PERIOD);
`ifdef FWUPD_UADDR_ZERO_EN
        check("zero_seen", zeros, 32'd1);
`else
        check("zero_seen", zeros, 32'd0);
`endif
        // Continuing past the seed: wrap must drop on the next step.
        tick(1'b1);
        check("after_wrap_uaddr", {24'h0, uaddr}, 32'h02);
        check("after_wrap_pulse", {31'h0, wrap}, 32'h0);
        tick(1'b0);
        check("idle_hold", {24'h0, uaddr}, 32'h02);
        check("idle_wrap", {31'h0, wrap}, 32'h0);

        // Boundary 0x80 -> next state.
        do_reset();
        model = 8'h01;
        for (int n = 0; n < 300; n++) begin
            if (model == 8'h80) break;
            tick(1'b1);
            model = ref_next(model);
        end
        check("reach_80", {24'h0, uaddr}, 32'h80);
        tick(1'b1);
`ifdef FWUPD_UADDR_ZERO_EN
        check("after_80", {24'h0, uaddr}, 32'h00);
        tick(1'b1);
        check("after_00", {24'h0, uaddr}, 32'h01);
`else
        check("after_80", {24'h0, uaddr}, 32'h01);
`endif
        check("after_80_wrap", {31'h0, wrap}, 32'h1);
        tick(1'b0);

        // Reset mid-sequence, not aligned to a clock edge.
        do_reset();
        for (int n = 0; n < 20; n++) tick(1'b1);
        check("pre_abort_moved", {31'h0, (uaddr != 8'h01)}, 32'h1);
        @(negedge clk);
        ce = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("abort_uaddr", {24'h0, uaddr}, 32'h01);
        check("abort_wrap", {31'h0, wrap}, 32'h0);
        // Reset wins over enable.
        tick(1'b1);
        check("rst_and_ce", {24'h0, uaddr}, 32'h01);
        tick(1'b1);
        check("rst_and_ce_2", {24'h0, uaddr}, 32'h01);
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b0;
        tick(1'b1);
        check("restart_step", {24'h0, uaddr}, 32'h02);
        check("restart_wrap", {31'h0, wrap}, 32'h0);
        tick(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
